pipelined_mips_cpu: RTL and testbench
=====================================

Name: pipelined_mips_cpu

Overview:
- Five-stage (IF, ID, EX, MEM, WB) pipelined 32-bit MIPS-subset core with an internal 32x32 general register file.
- Instruction words arrive on i_datain; load data arrives on d_datain; store data leaves on d_dataout.
- External memories handle addressing; the core exposes the EX-stage result internally as reg_C for bench observation.

Parameters:
- None.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- start  input  1  asynchronous active-low reset (0 = reset, 1 = run).
- i_datain  input  32  instruction word to be fetched at the next rising edge.
- d_datain  input  32  load data, sampled at the edge ending the MEM stage.
- d_dataout  output  32  store data of the instruction currently in MEM.

Behaviour:
- Reset (start=0, asynchronous): pc, instr, reg_A, reg_B, reg_C, reg_C1, all pipeline control fields, d_dataout and gr[0..31] are cleared to 0. Reset held mid-run aborts all in-flight instructions.
- 0x00000000 is a NOP: sll to gr0, which has no effect.
- Supported instructions:
  - R-type (op 000000) funct add 100000, sub 100010, and 100100, or 100101, slt 101010; destination is rd.
  - lw 100011: rt <= mem[gr[rs] + sext(imm)].
  - sw 101011.
  - beq 000100, bne 000101.
  - j 000010.
  - Unknown opcodes and functs behave as NOP.
- Arithmetic: 32-bit wraparound, no overflow trap. slt is signed. Immediates are sign-extended.
- gr[0] always reads 0; writes to it are discarded.
- Pipeline timing, for an instruction latched into instr at edge E:
  - IF (edge E): instr <= i_datain; pc <= pc+4, unless a redirect is pending.
  - ID (edge E+1): reg_A <= gr[rs]; reg_B <= gr[rt]; sign-extended imm and dest/control are latched.
  - EX (edge E+2): reg_C <= ALU result. For lw/sw the ALU result is the effective address reg_A + imm. Store data is forwarded to d_dataout.
  - MEM (edge E+3): reg_C1 <= d_datain for lw, else reg_C.
  - WB (edge E+4): gr[dest] <= reg_C1 if the instruction writes a register.
- Register file is write-through: an ID read of the register being written in WB that cycle returns the new value.
- No other forwarding and no interlocks. Software must place at least 2 independent instructions or NOPs between a producer and a dependent consumer.
- Branch/jump resolution in ID:
  - j target = {pc_plus4[31:28], instr[25:0], 2'b00}.
  - beq/bne compare the ID-stage register values; taken target = pc_plus4 + (sext(imm)<<2), where pc_plus4 is the address of the branch plus 4.
  - The redirect loads pc at the edge that latches the next word, so exactly one delay-slot instruction always executes.
- sw writes no register. d_dataout holds rt data from EX for every instruction and is meaningful only for sw.
- Internal state names pc, instr, reg_A, reg_B, reg_C, reg_C1 and gr[] exist with exactly these meanings, for bench probing.

Test Plan:
- Reset: start=0 then 1, NOPs fed -> pc=0 during reset, then 4, 8, 12 on successive edges; all gr remain 0.
- Load: lw gr1,1(gr0) followed by NOPs, d_datain=0x000000ab held -> reg_C=0x00000001 after 3 edges; gr1=0x000000ab after 5 edges.
- Dependent add:
  - Stimulus: lw gr1 (d=0xab); lw gr2,2(gr0) (d=0x00003c00 during its MEM); NOP; NOP; add gr3,gr1,gr2.
  - Required: gr3=0x00003cab four edges after the add is latched.
- Jump: j 0 fetched at pc=0x10 with delay-slot add gr4,gr1,gr1 -> pc goes 0x14 then 0x00; gr4=0x156 (delay slot executed).
- Store and branch:
  - sw gr3,4(gr0) -> during MEM, reg_C=4 and d_dataout=0x00003cab; no gr changes.
  - beq gr0,gr0,-2 -> taken one delay slot later.
- gr0/slt:
  - add gr0,gr1,gr1 -> gr0 stays 0.
  - slt gr5,gr1,gr2 -> 1.
  - sub gr6,gr1,gr2 -> 0xffffc4ab.

Source files
------------

// File: rtl/pipelined_mips_cpu.sv
// Five-stage MIPS-subset core (IF/ID/EX/MEM/WB) with a write-through 32x32 register file.
// Branches and jumps resolve in ID, giving exactly one delay slot; there is no forwarding and no interlock.
module pipelined_mips_cpu (
  input  logic        clock,
  input  logic        start,
  input  logic [31:0] i_datain,
  input  logic [31:0] d_datain,
  output logic [31:0] d_dataout
);
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  logic [31:0] pc, instr, reg_A, reg_B, reg_C, reg_C1;
  logic [31:0] gr [0:31];

  alu_op_e     r_ex_alu;
  logic        r_ex_use_imm, r_ex_wr, r_ex_ld;
  logic [31:0] r_ex_imm;
  logic [4:0]  r_ex_dest, r_mem_dest, r_wb_dest;
  logic        r_mem_wr, r_mem_ld, r_wb_wr;

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_dest;
  logic [31:0] w_imm, w_pc_plus4, w_rs_val, w_rt_val, w_target, w_opb, w_alu_res;
  logic        w_use_imm, w_wr, w_ld, w_redirect;
  alu_op_e     w_alu;
  logic        w_unused;

  assign w_op       = instr[31:26];
  assign w_rs       = instr[25:21];
  assign w_rt       = instr[20:16];
  assign w_rd       = instr[15:11];
  assign w_funct    = instr[5:0];
  assign w_imm      = {{16{instr[15]}}, instr[15:0]};
  assign w_unused   = ^instr[10:6];
  // instr was fetched from pc-4, so pc already equals the branch address plus 4
  assign w_pc_plus4 = pc;

  assign w_rs_val = (w_rs == 5'd0) ? '0 :
                    (r_wb_wr && r_wb_dest == w_rs) ? reg_C1 : gr[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? '0 :
                    (r_wb_wr && r_wb_dest == w_rt) ? reg_C1 : gr[w_rt];

  always_comb begin
    w_alu      = ALU_ADD;
    w_use_imm  = 1'b0;
    w_wr       = 1'b0;
    w_ld       = 1'b0;
    w_dest     = w_rd;
    w_redirect = 1'b0;
    w_target   = w_pc_plus4 + {w_imm[29:0], 2'b00};
    case (w_op)
      6'b000000: begin
        w_wr = 1'b1;
        case (w_funct)
          6'b100000: w_alu = ALU_ADD;
          6'b100010: w_alu = ALU_SUB;
          6'b100100: w_alu = ALU_AND;
          6'b100101: w_alu = ALU_OR;
          6'b101010: w_alu = ALU_SLT;
          default:   w_wr  = 1'b0;
        endcase
      end
      6'b100011: begin
        w_use_imm = 1'b1;
        w_wr      = 1'b1;
        w_ld      = 1'b1;
        w_dest    = w_rt;
      end
      6'b101011: w_use_imm  = 1'b1;
      6'b000100: w_redirect = (w_rs_val == w_rt_val);
      6'b000101: w_redirect = (w_rs_val != w_rt_val);
      6'b000010: begin
        w_redirect = 1'b1;
        w_target   = {w_pc_plus4[31:28], instr[25:0], 2'b00};
      end
      default: ;
    endcase
  end

  assign w_opb = r_ex_use_imm ? r_ex_imm : reg_B;

  always_comb begin
    w_alu_res = reg_A + w_opb;
    case (r_ex_alu)
      ALU_ADD: w_alu_res = reg_A + w_opb;
      ALU_SUB: w_alu_res = reg_A - w_opb;
      ALU_AND: w_alu_res = reg_A & w_opb;
      ALU_OR:  w_alu_res = reg_A | w_opb;
      ALU_SLT: w_alu_res = {31'd0, $signed(reg_A) < $signed(w_opb)};
      default: w_alu_res = reg_A + w_opb;
    endcase
  end

  always_ff @(posedge clock or negedge start) begin
    if (!start) begin
      pc           <= '0;
      instr        <= '0;
      reg_A        <= '0;
      reg_B        <= '0;
      reg_C        <= '0;
      reg_C1       <= '0;
      d_dataout    <= '0;
      r_ex_alu     <= ALU_ADD;
      r_ex_use_imm <= 1'b0;
      r_ex_imm     <= '0;
      r_ex_dest    <= '0;
      r_ex_wr      <= 1'b0;
      r_ex_ld      <= 1'b0;
      r_mem_dest   <= '0;
      r_mem_wr     <= 1'b0;
      r_mem_ld     <= 1'b0;
      r_wb_dest    <= '0;
      r_wb_wr      <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) gr[i[4:0]] <= '0;
    end else begin
      instr        <= i_datain;
      pc           <= w_redirect ? w_target : pc + 32'd4;
      reg_A        <= w_rs_val;
      reg_B        <= w_rt_val;
      r_ex_alu     <= w_alu;
      r_ex_use_imm <= w_use_imm;
      r_ex_imm     <= w_imm;
      r_ex_dest    <= w_dest;
      r_ex_wr      <= w_wr;
      r_ex_ld      <= w_ld;
      reg_C        <= w_alu_res;
      d_dataout    <= reg_B;
      r_mem_dest   <= r_ex_dest;
      r_mem_wr     <= r_ex_wr;
      r_mem_ld     <= r_ex_ld;
      reg_C1       <= r_mem_ld ? d_datain : reg_C;
      r_wb_dest    <= r_mem_dest;
      r_wb_wr      <= r_mem_wr;
      if (r_wb_wr && r_wb_dest != 5'd0) gr[r_wb_dest] <= reg_C1;
    end
  end
endmodule

// File: tb/tb_pipelined_mips_cpu.sv
// Bench for pipelined_mips_cpu: an instruction-level model executes each word as it is fetched and
// schedules its visible effects (reg_C, d_dataout, register writeback, pc) by pipeline depth.
module tb_pipelined_mips_cpu;
  logic        clock = 1'b0;
  logic        start = 1'b0;
  logic [31:0] i_datain = '0;
  logic [31:0] d_datain = '0;
  logic [31:0] d_dataout;

  always #5 clock = ~clock;

  pipelined_mips_cpu dut (
    .clock(clock),
    .start(start),
    .i_datain(i_datain),
    .d_datain(d_datain),
    .d_dataout(d_dataout)
  );

  localparam int MAXF = 4096;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_arch [32];
  logic [31:0] m_vis  [32];
  logic [31:0] m_pc, m_tgt, t_tgt;
  logic        m_pend, t_taken;
  int          k;
  int          last_wr [32];
  logic        cmp_en = 1'b0;

  logic        f_regc_v [MAXF];
  logic [31:0] f_regc   [MAXF];
  logic        f_sw     [MAXF];
  logic [31:0] f_swd    [MAXF];
  logic        f_wb     [MAXF];
  logic [4:0]  f_wbd    [MAXF];
  logic [31:0] f_wbv    [MAXF];
  logic        f_ld     [MAXF];
  logic [31:0] f_ldd    [MAXF];
  logic        f_br     [MAXF];

  logic [31:0] dir_w  [20];
  logic [31:0] dir_ld [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) begin
      m_arch[i]  = '0;
      m_vis[i]   = '0;
      last_wr[i] = -100;
    end
    m_pc   = '0;
    m_pend = 1'b0;
    m_tgt  = '0;
    k      = -1;
  endtask

  // ISA-level execution of one fetched word, in program order
  task automatic exec(input int kk, input logic [31:0] w, input logic [31:0] ld_val);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, dst;
    logic [31:0] a, b, imm, pc4, res;
    logic        wr;
    op  = w[31:26]; fn = w[5:0];
    rs  = w[25:21]; rt = w[20:16]; rd = w[15:11];
    a   = m_arch[rs]; b = m_arch[rt];
    imm = {{16{w[15]}}, w[15:0]};
    pc4 = m_pc + 32'd4;
    wr = 1'b0; dst = rd; res = '0;
    f_regc_v[kk] = 1'b0; f_sw[kk] = 1'b0; f_wb[kk] = 1'b0; f_ld[kk] = 1'b0;
    f_br[kk] = (op == 6'h04) || (op == 6'h05) || (op == 6'h02);
    t_taken = 1'b0; t_tgt = '0;
    case (op)
      6'h00: begin
        wr = 1'b1;
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: wr = 1'b0;
        endcase
        if (wr) begin f_regc_v[kk] = 1'b1; f_regc[kk] = res; end
      end
      6'h23: begin
        f_regc_v[kk] = 1'b1; f_regc[kk] = a + imm;
        f_ld[kk] = 1'b1; f_ldd[kk] = ld_val;
        wr = 1'b1; dst = rt; res = ld_val;
      end
      6'h2b: begin
        f_regc_v[kk] = 1'b1; f_regc[kk] = a + imm;
        f_sw[kk] = 1'b1; f_swd[kk] = b;
      end
      6'h04: begin t_taken = (a == b); t_tgt = pc4 + (imm << 2); end
      6'h05: begin t_taken = (a != b); t_tgt = pc4 + (imm << 2); end
      6'h02: begin t_taken = 1'b1; t_tgt = {pc4[31:28], w[25:0], 2'b00}; end
      default: ;
    endcase
    if (wr) begin
      f_wb[kk] = 1'b1; f_wbd[kk] = dst; f_wbv[kk] = res;
      if (dst != 5'd0) begin
        m_arch[dst]  = res;
        last_wr[dst] = kk;
      end
    end
  endtask

  task automatic step(input logic [31:0] w, input logic [31:0] ld_val);
    int kk;
    kk = k + 1;
    exec(kk, w, ld_val);
    i_datain = w;
    d_datain = (kk >= 3 && f_ld[kk-3]) ? f_ldd[kk-3] : $urandom;
    @(posedge clock);
    #1;
    k = kk;
    m_pc = m_pend ? m_tgt : m_pc + 32'd4;
    m_pend = t_taken;
    m_tgt  = t_tgt;
    if (k >= 4 && f_wb[k-4] && f_wbd[k-4] != 5'd0) m_vis[f_wbd[k-4]] = f_wbv[k-4];
    cmp_en = 1'b1;
  endtask

  function automatic logic [4:0] pick_src(input int kk);
    logic [4:0] r;
    for (int t = 0; t < 6; t++) begin
      r = 5'($urandom_range(0, 31));
      if (r == 5'd0 || kk - last_wr[r] >= 3) return r;
    end
    return 5'd0;
  endfunction

  function automatic bit is_real_funct(input logic [5:0] f);
    return f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a;
  endfunction

  function automatic bit is_real_op(input logic [5:0] o);
    return o == 6'h00 || o == 6'h02 || o == 6'h04 || o == 6'h05 || o == 6'h23 || o == 6'h2b;
  endfunction

  task automatic gen(input int kk, output logic [31:0] w, output logic [31:0] ldv);
    int          sel;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] rnd;
    logic [5:0]  f, o;
    logic [5:0]  ftab [5];
    ftab[0] = 6'h20; ftab[1] = 6'h22; ftab[2] = 6'h24; ftab[3] = 6'h25; ftab[4] = 6'h2a;
    sel = $urandom_range(0, 15);
    if (kk >= 1 && f_br[kk-1] && sel >= 9 && sel <= 11) sel = 0;
    rs  = pick_src(kk);
    rt  = pick_src(kk);
    rd  = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    rnd = $urandom;
    ldv = $urandom;
    case (sel)
      6, 7:    w = {6'h23, rs, rd, imm};
      8:       w = {6'h2b, rs, rt, imm};
      9:       w = {6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : rt, imm};
      10:      w = {6'h05, rs, rt, imm};
      11:      w = {6'h02, rnd[25:0]};
      12:      w = '0;
      13: begin
        f = 6'($urandom);
        while (is_real_funct(f)) f = 6'($urandom);
        w = {6'h00, rs, rt, rd, rnd[4:0], f};
      end
      14: begin
        o = 6'($urandom);
        while (is_real_op(o)) o = 6'($urandom);
        w = {o, rnd[25:0]};
      end
      default: w = {6'h00, rs, rt, rd, 5'd0, ftab[$urandom_range(0, 4)]};
    endcase
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("pc", dut.pc, m_pc);
      for (int i = 0; i < 32; i++) chk($sformatf("gr%0d", i), dut.gr[i], m_vis[i]);
      if (k >= 2 && f_regc_v[k-2]) chk("reg_C", dut.reg_C, f_regc[k-2]);
      if (k >= 2 && f_sw[k-2])     chk("d_dataout", d_dataout, f_swd[k-2]);
    end
  end

  task automatic check_all_clear(input string tag);
    chk({tag, "_pc"}, dut.pc, 32'h0);
    chk({tag, "_instr"}, dut.instr, 32'h0);
    chk({tag, "_reg_A"}, dut.reg_A, 32'h0);
    chk({tag, "_reg_B"}, dut.reg_B, 32'h0);
    chk({tag, "_reg_C"}, dut.reg_C, 32'h0);
    chk({tag, "_reg_C1"}, dut.reg_C1, 32'h0);
    chk({tag, "_d_dataout"}, d_dataout, 32'h0);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_gr%0d", tag, i), dut.gr[i], 32'h0);
  endtask

  initial begin
    logic [31:0] w, ldv;
    for (int i = 0; i < 20; i++) begin dir_w[i] = '0; dir_ld[i] = '0; end
    dir_w[0]  = 32'h8C010001; dir_ld[0] = 32'h000000ab;
    dir_w[1]  = 32'h8C020002; dir_ld[1] = 32'h00003c00;
    dir_w[4]  = 32'h08000000;
    dir_w[5]  = 32'h00212020;
    dir_w[6]  = 32'h00221820;
    dir_w[9]  = 32'hAC030004;
    dir_w[10] = 32'h00210020;
    dir_w[11] = 32'h0022282A;
    dir_w[12] = 32'h00223022;
    dir_w[13] = 32'h1000FFFE;

    reset_model();
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all_clear("reset");
    @(negedge clock);
    start = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(dir_w[i], dir_ld[i]);
      case (i)
        0:  chk("lit_pc_e0", dut.pc, 32'h4);
        1:  chk("lit_pc_e1", dut.pc, 32'h8);
        2: begin
          chk("lit_pc_e2", dut.pc, 32'hc);
          chk("lit_lw_regC", dut.reg_C, 32'h1);
        end
        4: begin
          chk("lit_lw_gr1", dut.gr[1], 32'h000000ab);
          chk("lit_j_pc1", dut.pc, 32'h14);
        end
        5:  chk("lit_j_pc2", dut.pc, 32'h0);
        9:  chk("lit_slot_gr4", dut.gr[4], 32'h00000156);
        10: chk("lit_add_gr3", dut.gr[3], 32'h00003cab);
        11: begin
          chk("lit_sw_regC", dut.reg_C, 32'h4);
          chk("lit_sw_data", d_dataout, 32'h00003cab);
        end
        13: chk("lit_beq_pc1", dut.pc, 32'h20);
        14: begin
          chk("lit_beq_pc2", dut.pc, 32'h18);
          chk("lit_gr0", dut.gr[0], 32'h0);
        end
        15: chk("lit_slt_gr5", dut.gr[5], 32'h1);
        16: chk("lit_sub_gr6", dut.gr[6], 32'hffffc4ab);
        default: ;
      endcase
    end

    for (int i = 0; i < 1200; i++) begin
      gen(k + 1, w, ldv);
      step(w, ldv);
    end

    #2;
    start = 1'b0;
    cmp_en = 1'b0;
    #1;
    check_all_clear("midreset");
    reset_model();
    @(posedge clock);
    @(negedge clock);
    start = 1'b1;

    for (int i = 0; i < 800; i++) begin
      gen(k + 1, w, ldv);
      step(w, ldv);
    end

    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
